ledger_reader: RTL and testbench

- Read-side counterpart to the transaction/memory write path: fetches one 48-bit ledger record from the shared ledger RAM on request.
- Selects one 24-bit balance field from the record and converts it to 8-digit packed BCD for the display path.
- Shares the RAM port with memory_control through a req/grant handshake. It never writes.

---
 rtl/ledger_reader.sv | 189 ++++++++++++++++++
 tb/tb_ledger_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ledger_reader.sv
// ledger_reader: fetches one 48-bit ledger record over the shared RAM port and converts the selected balance field to packed BCD.
// Define LEDGER_READER_SEG_EN to add the registered 7-segment output hex_seg.
module ledger_reader #(
  parameter int ADDR_WIDTH   = 4,
  parameter int READ_LATENCY = 2,
  parameter int FIELD_WIDTH  = 24
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start_read,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  field_sel,
  input  logic                  mem_grant,
  input  logic [47:0]           mem_data,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  busy,
  output logic                  done,
  output logic [47:0]           record_out,
  output logic [31:0]           bcd_out,
`ifdef LEDGER_READER_SEG_EN
  output logic [55:0]           hex_seg,
`endif
  output logic [2:0]            state_dbg
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_WAIT, S_CONVERT, S_DONE} state_t;

  localparam int SW = 32 + FIELD_WIDTH;
  localparam int CW = $clog2(FIELD_WIDTH + READ_LATENCY + 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic                  sel_q, sel_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         shift_q, shift_d, shift_nxt;
  logic [47:0]           record_q, record_d;
  logic [31:0]           bcd_q, bcd_d;

  // One double-dabble step on {bcd, binary}: correct digits >= 5, then shift.
  always_comb begin
    shift_nxt = shift_q;
    for (int i = 0; i < 8; i++) begin
      if (shift_nxt[FIELD_WIDTH+4*i +: 4] >= 4'd5)
        shift_nxt[FIELD_WIDTH+4*i +: 4] = shift_nxt[FIELD_WIDTH+4*i +: 4] + 4'd3;
    end
    shift_nxt = shift_nxt << 1;
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    sel_d         = sel_q;
    mem_address_d = mem_address_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    record_d      = record_q;
    bcd_d         = bcd_q;
    mem_req       = 1'b0;
    mem_rden      = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start_read) begin
          addr_d  = read_addr;
          sel_d   = field_sel;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_grant) begin
          mem_address_d = addr_q;
          state_d       = S_ADDR;
        end
      end
      S_ADDR: begin
        mem_req  = 1'b1;
        mem_rden = 1'b1;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // A revoked grant here is the arbiter's fault; the read still completes.
        mem_req = 1'b1;
        if (cnt_q == CW'(READ_LATENCY - 1)) begin
          record_d = mem_data;
          shift_d  = {32'd0, sel_q ? mem_data[FIELD_WIDTH +: FIELD_WIDTH]
                                   : mem_data[0 +: FIELD_WIDTH]};
          cnt_d    = '0;
          state_d  = S_CONVERT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CONVERT: begin
        shift_d = shift_nxt;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(FIELD_WIDTH - 1)) begin
          bcd_d   = shift_nxt[SW-1 -: 32];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      sel_q         <= 1'b0;
      mem_address_q <= '0;
      cnt_q         <= '0;
      shift_q       <= '0;
      record_q      <= '0;
      bcd_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      sel_q         <= sel_d;
      mem_address_q <= mem_address_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      record_q      <= record_d;
      bcd_q         <= bcd_d;
    end
  end

  assign mem_address = mem_address_q;
  assign record_out  = record_q;
  assign bcd_out     = bcd_q;
  assign state_dbg   = state_q;

`ifdef LEDGER_READER_SEG_EN
  logic [55:0] hex_q, hex_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Blank zeros from the top digit down until the first nonzero; digit 0 always shows.
  function automatic logic [55:0] seg_word(input logic [31:0] b);
    logic lead;
    seg_word = '0;
    lead     = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (i != 0 && lead && b[4*i +: 4] == 4'd0) begin
        seg_word[7*i +: 7] = 7'h7F;
      end else begin
        lead               = 1'b0;
        seg_word[7*i +: 7] = seg7(b[4*i +: 4]);
      end
    end
  endfunction

  always_comb begin
    hex_d = hex_q;
    if (state_q == S_CONVERT && cnt_q == CW'(FIELD_WIDTH - 1))
      hex_d = seg_word(shift_nxt[SW-1 -: 32]);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) hex_q <= {{7{7'h7F}}, 7'h40};
    else         hex_q <= hex_d;
  end

  assign hex_seg = hex_q;
`endif
endmodule

// File: tb/tb_ledger_reader.sv
// tb_ledger_reader: drives ledger_reader against a behavioural RAM with fixed read latency
// and checks records, BCD results, timing and handshake behaviour against a decimal model.
`timescale 1ns/1ps
module tb_ledger_reader;
  localparam int AW = 4;
  localparam int RL = 2;
  localparam int FW = 24;

  // ---------------- clock / reset ----------------
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #10 clock = ~clock;

  logic          start_read = 1'b0;
  logic [AW-1:0] read_addr  = '0;
  logic          field_sel  = 1'b0;
  logic          mem_grant  = 1'b0;
  logic [47:0]   mem_data;
  logic          mem_req, mem_rden, busy, done;
  logic [AW-1:0] mem_address;
  logic [47:0]   record_out;
  logic [31:0]   bcd_out;
  logic [2:0]    state_dbg;
`ifdef LEDGER_READER_SEG_EN
  logic [55:0]   hex_seg;
`endif

  ledger_reader #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .FIELD_WIDTH(FW)) dut (
    .clock(clock), .resetn(resetn), .start_read(start_read), .read_addr(read_addr),
    .field_sel(field_sel), .mem_grant(mem_grant), .mem_data(mem_data),
    .mem_req(mem_req), .mem_address(mem_address), .mem_rden(mem_rden), .busy(busy),
    .done(done), .record_out(record_out), .bcd_out(bcd_out),
`ifdef LEDGER_READER_SEG_EN
    .hex_seg(hex_seg),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- RAM model: data valid RL edges after rden is sampled, garbage otherwise ----------------
  logic [47:0] ram  [16];
  logic [47:0] pipe [RL];
  always @(posedge clock) begin
    pipe[0] <= mem_rden ? ram[mem_address] : 48'({$urandom, $urandom});
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data = pipe[RL-1];

  // ---------------- scoreboard / reference model ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [79:0] exp_q[$];

  function automatic logic [31:0] model_bcd(input logic [47:0] rec, input logic sel);
    int v;
    v = sel ? int'(rec[47:24]) : int'(rec[23:0]);
    model_bcd = '0;
    for (int i = 0; i < 8; i++) begin
      model_bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

`ifdef LEDGER_READER_SEG_EN
  function automatic logic [55:0] model_seg(input logic [31:0] b);
    logic [6:0] tbl [10];
    int top;
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    top = 0;
    for (int i = 0; i < 8; i++) if (b[4*i +: 4] != 0) top = i;
    for (int i = 0; i < 8; i++) model_seg[7*i +: 7] = (i > top) ? 7'h7F : tbl[b[4*i +: 4]];
  endfunction
`endif

  // ---------------- driver ----------------
  int   obs_lat, obs_rden, obs_done, obs_req_rises, obs_early_rden, obs_busy_gap;
  logic obs_busy_after, obs_timeout;

  // Launch one read; edges counted from the start_read sampling edge (edge 0).
  // gd: mem_grant held low through edge gd. ign_at: edge after which a stray start_read pulse is driven.
  task automatic do_read(input logic [AW-1:0] a, input logic s, input int gd, input int ign_at);
    int   k;
    logic prev_req;
    k = 0;
    while (busy && k < 100) begin @(posedge clock); #1; k++; end
    mem_grant  = (gd == 0);
    start_read = 1'b1;
    read_addr  = a;
    field_sel  = s;
    @(posedge clock); #1;
    start_read = 1'b0;
    read_addr  = AW'($urandom);
    field_sel  = 1'($urandom);
    obs_lat = -1; obs_rden = 0; obs_done = 0; obs_req_rises = 0;
    obs_early_rden = 0; obs_busy_gap = 0; obs_busy_after = 1'b1; obs_timeout = 1'b0;
    prev_req = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clock); #1;
      if (mem_rden) obs_rden++;
      if (mem_rden && e <= gd) obs_early_rden++;
      if (mem_req && !prev_req) obs_req_rises++;
      prev_req = mem_req;
      if (obs_lat < 0 && !busy) obs_busy_gap++;
      if (done) begin
        obs_done++;
        if (obs_lat < 0) obs_lat = e;
      end
      if (obs_lat >= 0 && e == obs_lat + 1) obs_busy_after = busy;
      if (gd > 0 && e == gd) mem_grant = 1'b1;
      if (ign_at > 0 && e == ign_at) begin start_read = 1'b1; read_addr = 4'd5; end
      if (ign_at > 0 && e == ign_at + 1) start_read = 1'b0;
      if (obs_lat >= 0 && e >= obs_lat + 3) break;
    end
    if (obs_lat < 0) obs_timeout = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    #5;
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_cmp++; if (mem_rden !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rden got %b want 0", mem_rden); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (mem_address !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_address); end
    n_cmp++; if (record_out !== 48'd0) begin n_fail++; $display("FAIL reset_record got %h want 0", record_out); end
    n_cmp++; if (bcd_out !== 32'd0) begin n_fail++; $display("FAIL reset_bcd got %h want 0", bcd_out); end
`ifdef LEDGER_READER_SEG_EN
    n_cmp++; if (hex_seg !== {{7{7'h7F}}, 7'h40}) begin n_fail++; $display("FAIL reset_hex got %h want %h", hex_seg, {{7{7'h7F}}, 7'h40}); end
`endif
    #20 resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    ram[3] = 48'h003039_000001;
    do_read(4'd3, 1'b1, 0, 0);
    n_cmp++; if (obs_lat !== 28) begin n_fail++; $display("FAIL basic_latency got %0d want 28", obs_lat); end
    n_cmp++; if (obs_done !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", obs_done); end
    n_cmp++; if (obs_rden !== 1) begin n_fail++; $display("FAIL basic_rden_count got %0d want 1", obs_rden); end
    n_cmp++; if (obs_req_rises !== 1) begin n_fail++; $display("FAIL basic_req_rises got %0d want 1", obs_req_rises); end
    n_cmp++; if (obs_busy_gap !== 0) begin n_fail++; $display("FAIL basic_busy_gap got %0d want 0", obs_busy_gap); end
    n_cmp++; if (obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b want 0", obs_busy_after); end
    n_cmp++; if (mem_address !== 4'd3) begin n_fail++; $display("FAIL basic_addr_hold got %h want 3", mem_address); end
    n_cmp++; if (record_out !== 48'h003039_000001) begin n_fail++; $display("FAIL basic_record got %h want 003039000001", record_out); end
    n_cmp++; if (bcd_out !== 32'h00012345) begin n_fail++; $display("FAIL basic_bcd got %h want 00012345", bcd_out); end
  endtask

  task automatic test_field0_max();
    ram[15] = 48'h000000_FFFFFF;
    do_read(4'd15, 1'b0, 0, 0);
    n_cmp++; if (obs_done !== 1) begin n_fail++; $display("FAIL max_done_count got %0d want 1", obs_done); end
    n_cmp++; if (bcd_out !== 32'h16777215) begin n_fail++; $display("FAIL max_bcd got %h want 16777215", bcd_out); end
    n_cmp++; if (record_out !== 48'h000000_FFFFFF) begin n_fail++; $display("FAIL max_record got %h want 000000ffffff", record_out); end
  endtask

  task automatic test_grant_delay();
    ram[9] = 48'h0F423F_00007B;
    do_read(4'd9, 1'b1, 10, 0);
    n_cmp++; if (obs_lat !== 38) begin n_fail++; $display("FAIL gdelay_latency got %0d want 38", obs_lat); end
    n_cmp++; if (obs_early_rden !== 0) begin n_fail++; $display("FAIL gdelay_early_rden got %0d want 0", obs_early_rden); end
    n_cmp++; if (obs_rden !== 1) begin n_fail++; $display("FAIL gdelay_rden_count got %0d want 1", obs_rden); end
    n_cmp++; if (obs_busy_gap !== 0) begin n_fail++; $display("FAIL gdelay_busy_gap got %0d want 0", obs_busy_gap); end
    n_cmp++; if (bcd_out !== 32'h00999999) begin n_fail++; $display("FAIL gdelay_bcd got %h want 00999999", bcd_out); end
  endtask

  task automatic test_ignored_start();
    ram[2] = 48'h000ABC_01E240;
    ram[5] = 48'h111111_222222;
    do_read(4'd2, 1'b0, 0, 10);
    n_cmp++; if (obs_req_rises !== 1) begin n_fail++; $display("FAIL ignore_req_rises got %0d want 1", obs_req_rises); end
    n_cmp++; if (obs_done !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", obs_done); end
    n_cmp++; if (record_out !== ram[2]) begin n_fail++; $display("FAIL ignore_record got %h want %h", record_out, ram[2]); end
    n_cmp++; if (bcd_out !== 32'h00123456) begin n_fail++; $display("FAIL ignore_bcd got %h want 00123456", bcd_out); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_convert();
    logic [31:0] exp_bcd;
    ram[6] = 48'h000000_0003E8;
    do_read(4'd6, 1'b0, 0, 0);
    mem_grant  = 1'b1;
    start_read = 1'b1;
    read_addr  = 4'd6;
    field_sel  = 1'b0;
    @(posedge clock); #1;
    start_read = 1'b0;
    repeat (10) @(posedge clock);
    #4 resetn = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_req got %b want 0", mem_req); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b want 0", done); end
    n_cmp++; if (bcd_out !== 32'd0) begin n_fail++; $display("FAIL rstmid_bcd got %h want 0", bcd_out); end
    n_cmp++; if (record_out !== 48'd0) begin n_fail++; $display("FAIL rstmid_record got %h want 0", record_out); end
    #3 resetn = 1'b1;
    ram[8] = 48'h0001F4_000000;
    exp_bcd = model_bcd(ram[8], 1'b1);
    do_read(4'd8, 1'b1, 0, 0);
    n_cmp++; if (obs_lat !== 28) begin n_fail++; $display("FAIL rstmid_next_latency got %0d want 28", obs_lat); end
    n_cmp++; if (bcd_out !== exp_bcd) begin n_fail++; $display("FAIL rstmid_next_bcd got %h want %h", bcd_out, exp_bcd); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic          s;
    int            gd;
    logic [79:0]   exp;
    for (int n = 0; n < 10; n++) begin
      a  = AW'($urandom_range(0, 15));
      s  = 1'($urandom_range(0, 1));
      gd = $urandom_range(0, 3);
      ram[a] = 48'({$urandom, $urandom});
      exp_q.push_back({ram[a], model_bcd(ram[a], s)});
      do_read(a, s, gd, 0);
      exp = exp_q.pop_front();
      n_cmp++; if (obs_timeout || obs_lat !== 28 + gd) begin n_fail++; $display("FAIL b2b_latency[%0d] got %0d want %0d", n, obs_lat, 28 + gd); end
      n_cmp++; if (record_out !== exp[79:32]) begin n_fail++; $display("FAIL b2b_record[%0d] got %h want %h", n, record_out, exp[79:32]); end
      n_cmp++; if (bcd_out !== exp[31:0]) begin n_fail++; $display("FAIL b2b_bcd[%0d] got %h want %h", n, bcd_out, exp[31:0]); end
`ifdef LEDGER_READER_SEG_EN
      n_cmp++; if (hex_seg !== model_seg(exp[31:0])) begin n_fail++; $display("FAIL b2b_hex[%0d] got %h want %h", n, hex_seg, model_seg(exp[31:0])); end
`endif
    end
  endtask

`ifdef LEDGER_READER_SEG_EN
  task automatic test_seg();
    ram[7] = 48'h000000_000007;
    do_read(4'd7, 1'b0, 0, 0);
    n_cmp++; if (hex_seg !== {{7{7'h7F}}, 7'h78}) begin n_fail++; $display("FAIL seg_seven got %h want %h", hex_seg, {{7{7'h7F}}, 7'h78}); end
  endtask
`endif

  // ---------------- sequence / final report ----------------
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 48'({$urandom, $urandom});
    test_reset();
    test_basic();
    test_field0_max();
    test_grant_delay();
    test_ignored_start();
    test_reset_mid_convert();
    test_back_to_back();
`ifdef LEDGER_READER_SEG_EN
    test_seg();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
